// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a byte stream (32-bit word count, then
// little-endian words), writes each word from address 0 and holds the core in reset.
module imem_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 'h6000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_idx;   // one bit wider so MAX_WORDS itself is representable
  logic [23:0]       asm_q;
  logic [31:0]       cnt;
  logic              go, xfer, word_end;
  logic [31:0]       word_val, word_nxt;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    go         = 1'b0;
    rx_ready   = (state == S_LEN) || (state == S_DATA);
    busy       = (state == S_LEN) || (state == S_DATA) || (state == S_FLUSH);
    core_rst_n = (state == S_IDLE) || (state == S_DONE);
    done       = (state == S_DONE);
    err        = (state == S_ERR);
    xfer       = rx_valid && rx_ready;
    word_end   = xfer && (byte_idx == 2'd3);
    word_val   = {rx_data, asm_q};
    word_nxt   = 32'(word_idx) + 32'd1;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          go        = 1'b1;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (word_end) begin
          if (word_val == 32'd0)                  state_nxt = S_DONE;
          else if (word_val > 32'(MAX_WORDS))     state_nxt = S_ERR;
          else                                    state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (word_end && (word_nxt == cnt)) state_nxt = S_FLUSH;
      end
      S_FLUSH: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly and write port; the 4th byte goes straight into wdata/cnt
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx <= '0;
      word_idx <= '0;
      asm_q    <= '0;
      cnt      <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (go) begin
        byte_idx <= '0;
        word_idx <= '0;
        asm_q    <= '0;
      end else if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= rx_data;
          2'd1:    asm_q[15:8]  <= rx_data;
          2'd2:    asm_q[23:16] <= rx_data;
          default: ;
        endcase
        if (byte_idx == 2'd3) begin
          if (state == S_LEN) begin
            cnt <= word_val;
          end else begin
            we       <= 1'b1;
            waddr    <= word_idx[ADDR_W-1:0];
            wdata    <= word_val;
            word_idx <= word_idx + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed write sequences and status timing.
module tb_imem_loader;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst, start, rx_valid, rx_ready, we, core_rst_n, busy, done, err;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  int n_chk  = 0;
  int n_pass = 0;
  int unsigned wa[$];
  logic [31:0] wd[$];

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS('h6000)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // we is a one-cycle pulse, so one negedge sample per write
  always @(negedge clk) if (we) begin
    wa.push_back(int'(waddr));
    wd.push_back(wdata);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int stall);
    rx_data = b; rx_valid = 1'b1; tick();
    rx_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      rx_data = 8'hA5;
      tick();
      chk("stall_no_we", {31'd0, we}, (i == 0) ? 32'(we) : 32'd0);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int stall);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], stall);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete();
  endtask

  task automatic check_two_word(input string tag);
    chk({tag, "_cnt"},   32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'd0);
      chk({tag, "_d0"}, wd[0], 32'h0010_0513);
      chk({tag, "_a1"}, wa[1], 32'd1);
      chk({tag, "_d1"}, wd[1], 32'h0000_006F);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    tick(); tick();
    chk("rst_ready", {31'd0, rx_ready},   32'd0);
    chk("rst_we",    {31'd0, we},         32'd0);
    chk("rst_crst",  {31'd0, core_rst_n}, 32'd1);
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_done",  {31'd0, done},       32'd0);
    chk("rst_err",   {31'd0, err},        32'd0);
    chk("rst_waddr", 32'(waddr),          32'd0);
    chk("rst_wdata", wdata,               32'd0);
    start = 1'b0; rx_valid = 1'b0; rst = 1'b1;
    tick();
    clear_log();

    // two-word load at full rate
    pulse_start();
    chk("full_ready", {31'd0, rx_ready}, 32'd1);
    chk("full_crst",  {31'd0, core_rst_n}, 32'd0);
    send_word(32'd2, 0);
    send_word(32'h0010_0513, 0);
    send_word(32'h0000_006F, 0);
    chk("full_we_flush",   {31'd0, we},   32'd1);
    chk("full_busy_flush", {31'd0, busy}, 32'd1);
    chk("full_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("full_done", {31'd0, done},       32'd1);
    chk("full_crst_done", {31'd0, core_rst_n}, 32'd1);
    chk("full_busy", {31'd0, busy},       32'd0);
    check_two_word("full");

    // same image with 3 idle cycles after every byte
    clear_log();
    pulse_start();
    chk("stl_done_clr", {31'd0, done}, 32'd0);
    send_word(32'd2, 3);
    send_word(32'h0010_0513, 3);
    send_word(32'h0000_006F, 3);
    chk("stl_done", {31'd0, done}, 32'd1);
    check_two_word("stl");

    // count zero
    clear_log();
    pulse_start();
    send_word(32'd0, 0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("zero_nowe", 32'(wa.size()), 32'd0);

    // oversize count, then recovery with a 1-word load
    clear_log();
    pulse_start();
    send_word(32'h0000_6001, 0);
    chk("ovr_err",   {31'd0, err},        32'd1);
    chk("ovr_ready", {31'd0, rx_ready},   32'd0);
    chk("ovr_crst",  {31'd0, core_rst_n}, 32'd0);
    rx_data = 8'h11; rx_valid = 1'b1; tick(); tick(); rx_valid = 1'b0;
    chk("ovr_still_err", {31'd0, err}, 32'd1);
    chk("ovr_nowe", 32'(wa.size()), 32'd0);
    pulse_start();
    chk("ovr_err_clr", {31'd0, err}, 32'd0);
    send_word(32'd1, 0);
    send_word(32'hEFBE_ADDE, 0);
    tick();
    chk("rec_done", {31'd0, done}, 32'd1);
    chk("rec_cnt", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      chk("rec_a0", wa[0], 32'd0);
      chk("rec_d0", wd[0], 32'hEFBE_ADDE);
    end

    // ignored start during DATA, then reset mid-word
    clear_log();
    pulse_start();
    send_word(32'd4, 0);
    send_word(32'h1111_1111, 0);
    start = 1'b1;
    send(8'h22, 0); send(8'h22, 0);
    start = 1'b0;
    send(8'h22, 0); send(8'h22, 0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    send(8'h33, 0); send(8'h33, 0);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mrst_ready", {31'd0, rx_ready},   32'd0);
    chk("mrst_we",    {31'd0, we},         32'd0);
    chk("mrst_busy",  {31'd0, busy},       32'd0);
    chk("mrst_done",  {31'd0, done},       32'd0);
    chk("mrst_crst",  {31'd0, core_rst_n}, 32'd1);
    chk("mrst_waddr", 32'(waddr),          32'd0);
    chk("mrst_wdata", wdata,               32'd0);
    tick(); tick();
    chk("mrst_cnt", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("mrst_a1", wa[1], 32'd1);
      chk("mrst_d1", wd[1], 32'h2222_2222);
    end

    clear_log();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h0010_0513, 0);
    send_word(32'h0000_006F, 0);
    tick();
    chk("after_done", {31'd0, done}, 32'd1);
    check_two_word("after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. It accepts a byte stream over a valid/ready handshake carrying a 32-bit word count followed by that many little-endian instruction words. It issues one synchronous write per word into instruction memory, word-addressed from 0. It holds the core in reset while loading, so fetch never reads a partially written image.

## Interface
- ADDR_W, 15: width of the word address; must cover MAX_WORDS.
- MAX_WORDS, 'h6000: instruction memory depth in 32-bit words; word counts above this are rejected.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets the block).
- start  in  1  single-cycle load request; sampled only in IDLE, DONE, ERR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
- we  out  1  instruction-memory write enable; one-cycle pulse per word.
- waddr  out  ADDR_W  word address of the write (byte address = waddr<<2).
- wdata  out  32  instruction word.
- core_rst_n  out  1  active-low core reset; low while loading or in error.
- busy  out  1  load in progress.
- done  out  1  last load completed; sticky until the next accepted start or rst.
- err  out  1  last load rejected; sticky until the next accepted start or rst.

## Operation
- States: IDLE, LEN, DATA, FLUSH, DONE, ERR.
- IDLE → LEN on start. DONE/ERR → LEN on start. start in LEN/DATA/FLUSH is ignored.
- On the entry edge to LEN, clear:
  - byte index (2 bits)
  - word index
  - assembly register
  - done and err
- LEN: accept 4 bytes, LSB first, into count N (32 bits). On the 4th byte:
  - N == 0 → DONE.
  - N > MAX_WORDS → ERR.
  - Otherwise → DATA.
- DATA: accept bytes, LSB first. The byte index wraps 3 → 0. On each 4th byte, at that same edge:
  - wdata <= {rx_data, asm[23:0]}
  - waddr <= word index
  - we <= 1
  - word index += 1
- After the write of word N-1 is registered → FLUSH; otherwise stay in DATA.
- FLUSH: one cycle, no byte accepted, then → DONE.
- The comparison uses the full 32-bit N. Word index is ADDR_W+1 bits wide so that MAX_WORDS is representable.
- ERR: rx_ready stays 0. The remaining stream bytes are not consumed; upstream must flush them.
- rx_ready = 1 exactly in LEN and DATA, independent of rx_valid.
- busy = 1 in LEN, DATA, FLUSH.
- core_rst_n = 0 in LEN, DATA, FLUSH, ERR; 1 in IDLE and DONE.
- Every state change and output update waits for the next rising edge; nothing updates combinationally from rx_valid.

## Timing
- Reset values:
  - state IDLE
  - rx_ready 0, we 0, busy 0, done 0, err 0
  - core_rst_n 1
  - waddr 0, wdata 0
- rst low overrides start and any in-flight transfer; a partial word is discarded and no write is issued.
- start high at edge t → LEN from t; rx_ready=1 in cycle t+1.
- Byte accepted at edge k as the 4th byte of a word → we=1 during cycle k+1 only, with waddr/wdata valid that cycle. Memory captures the word at edge k+1.
- Last word accepted at edge k:
  - we at k+1 (FLUSH)
  - busy=0, done=1, core_rst_n=1 from k+2
  - The core's first fetch therefore follows the last write by at least one cycle.
- Full throughput: one byte per cycle, giving 4N+4 accepting cycles for a full load plus 1 FLUSH cycle.
- rx_valid deasserted mid-word: the byte index holds; there is no timeout.
- A write pulse can coincide with acceptance of the next word's first byte; both proceed.
- Bad count at edge k: err=1, core_rst_n=0, rx_ready=0 from k+1.

## Test plan
- Reset: hold rst=0 for 2 cycles while start=1 and rx_valid=1 → state stays IDLE, rx_ready=0, we=0, core_rst_n=1, done=0, err=0.
- Two-word load at full rate: start, then bytes 02 00 00 00, 13 05 10 00, 6F 00 00 00 back to back.
  - Expect we pulse with waddr=0, wdata=0x00100513.
  - Expect we pulse with waddr=1, wdata=0x0000006F.
  - Exactly 2 pulses; done=1 and core_rst_n=1 two cycles after the last byte.
- Stalled stream: same image with rx_valid dropped for 3 cycles after every byte → identical writes; no extra we; byte index never advances while rx_valid=0.
- Count zero: bytes 00 00 00 00 → no we; done=1 on the cycle after the 4th byte.
- Oversize: count 0x00006001 → err=1, rx_ready=0, core_rst_n=0, no writes; a subsequent start clears err and a valid 1-word load succeeds.
- Mid-load reset and ignored start:
  - start pulsed during DATA → no effect.
  - rst=0 after 2 bytes of word 3 → no write for word 3; outputs return to reset values; a new full load then writes from waddr=0.
